// File: rtl/sim_harness_ctrl_if.sv
// Core-side observation bus seen by the test-harness controller.
//   st_valid  store strobe, at most one store per cycle
//   st_addr   store address (AW bits)
//   st_data   store data (DW bits)
//   retire    one instruction retired this cycle
// Modports: master = core side (drives), slave = harness side (observes).
interface sim_harness_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          retire;

    modport master (output st_valid, output st_addr, output st_data, output retire);
    modport slave  (input  st_valid, input  st_addr, input  st_data, input  retire);
endinterface

// File: rtl/sim_harness_ctrl.sv
// Test-harness controller: sequences the core reset, counts run cycles and
// retired instructions, and ends the run on a TOHOST store (pass/fail),
// a cycle-budget timeout, or a retire-starvation hang.
//
// Optional feature: define HARNESS_SIGNATURE_EN to add the store-signature
// output sig (rotate-left-by-one XOR of every store data seen in RUN).
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   bus            store/retire observation bus (slave modport)
//   core_rst_n     active-low reset to the core
//   running        high in RUN
//   done           high in any terminal state
//   status         0 busy, 1 pass, 2 fail, 3 timeout/hang
//   hang           with status=3: 1 hang, 0 timeout
//   fail_code      st_data >> 1 captured on fail
//   cycle_count    cycles spent in RUN (saturating)
//   instret_count  retires counted in RUN (saturating)
//   sig            store signature (HARNESS_SIGNATURE_EN only)
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_RESET_SEQ| core held in reset, counting RST_CYCLES
// ST_RUN      | core running, counters active, watching TOHOST
// ST_PASS     | TOHOST store of 1 seen; core frozen
// ST_FAIL     | TOHOST store of odd value != 1 seen; core frozen
// ST_TIMEOUT  | cycle budget exhausted or hang detected; core frozen
module sim_harness_ctrl #(
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter logic [AW-1:0]   TOHOST_ADDR = 32'h0000_1000,
    parameter int              RST_CYCLES  = 4,
    parameter int              MAX_CYCLES  = 1000,
    parameter int              HANG_CYCLES = 64,
    parameter int              CW          = 32
) (
    input  logic                clk,
    input  logic                rst,
    sim_harness_ctrl_if.slave   bus,
    output logic                core_rst_n,
    output logic                running,
    output logic                done,
    output logic [1:0]          status,
    output logic                hang,
    output logic [DW-2:0]       fail_code,
`ifdef HARNESS_SIGNATURE_EN
    output logic [DW-1:0]       sig,
`endif
    output logic [CW-1:0]       cycle_count,
    output logic [CW-1:0]       instret_count
);

    typedef enum logic [2:0] {
        ST_RESET_SEQ = 3'd0,
        ST_RUN       = 3'd1,
        ST_PASS      = 3'd2,
        ST_FAIL      = 3'd3,
        ST_TIMEOUT   = 3'd4
    } state_t;

    localparam logic [1:0] STAT_BUSY    = 2'd0;
    localparam logic [1:0] STAT_PASS    = 2'd1;
    localparam logic [1:0] STAT_FAIL    = 2'd2;
    localparam logic [1:0] STAT_TIMEOUT = 2'd3;

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int IW = $clog2(HANG_CYCLES + 1);

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(HANG_CYCLES - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(MAX_CYCLES - 1);

    state_t        state;
    logic [RW-1:0] rst_cnt;
    logic [IW-1:0] idle_cnt;

    logic tohost_hit;
    logic term_store;
    logic pass_store;

    assign tohost_hit = bus.st_valid && (bus.st_addr == TOHOST_ADDR);
    // Even values written to TOHOST are not terminal and are ignored.
    assign term_store = tohost_hit && bus.st_data[0];
    assign pass_store = term_store && (bus.st_data == DW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RESET_SEQ;
            rst_cnt       <= '0;
            idle_cnt      <= '0;
            core_rst_n    <= 1'b0;
            running       <= 1'b0;
            done          <= 1'b0;
            status        <= STAT_BUSY;
            hang          <= 1'b0;
            fail_code     <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
`ifdef HARNESS_SIGNATURE_EN
            sig           <= '0;
`endif
        end else begin
            case (state)
                ST_RESET_SEQ: begin
                    core_rst_n <= 1'b0;
                    running    <= 1'b0;
                    if (rst_cnt == RST_LAST) begin
                        state      <= ST_RUN;
                        core_rst_n <= 1'b1;
                        running    <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + 1'b1;
                    if (bus.retire && (instret_count != '1))
                        instret_count <= instret_count + 1'b1;
                    idle_cnt <= bus.retire ? '0 : idle_cnt + 1'b1;
`ifdef HARNESS_SIGNATURE_EN
                    if (bus.st_valid)
                        sig <= {sig[DW-2:0], sig[DW-1]} ^ bus.st_data;
`endif
                    // Terminating store beats timeout, which beats hang.
                    if (term_store) begin
                        state      <= pass_store ? ST_PASS : ST_FAIL;
                        status     <= pass_store ? STAT_PASS : STAT_FAIL;
                        if (!pass_store)
                            fail_code <= bus.st_data[DW-1:1];
                        running    <= 1'b0;
                        done       <= 1'b1;
                        core_rst_n <= 1'b0;
                    end else if (cycle_count == CYC_LAST) begin
                        state      <= ST_TIMEOUT;
                        status     <= STAT_TIMEOUT;
                        hang       <= 1'b0;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        core_rst_n <= 1'b0;
                    end else if ((idle_cnt == IDLE_LAST) && !bus.retire) begin
                        state      <= ST_TIMEOUT;
                        status     <= STAT_TIMEOUT;
                        hang       <= 1'b1;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        core_rst_n <= 1'b0;
                    end
                end

                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    // Core frozen; results hold until rst.
                    core_rst_n <= 1'b0;
                    running    <= 1'b0;
                    done       <= 1'b1;
                end

                default: begin
                    state         <= ST_RESET_SEQ;
                    rst_cnt       <= '0;
                    idle_cnt      <= '0;
                    core_rst_n    <= 1'b0;
                    running       <= 1'b0;
                    done          <= 1'b0;
                    status        <= STAT_BUSY;
                    hang          <= 1'b0;
                    fail_code     <= '0;
                    cycle_count   <= '0;
                    instret_count <= '0;
`ifdef HARNESS_SIGNATURE_EN
                    sig           <= '0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_harness_ctrl.sv
module tb_sim_harness_ctrl;

    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam int          RSTC   = 4;
    localparam int          MAXC   = 20;
    localparam int          HANGC  = 8;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sim_harness_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    logic          core_rst_n;
    logic          running;
    logic          done;
    logic [1:0]    status;
    logic          hang;
    logic [DW-2:0] fail_code;
    logic [31:0]   cycle_count;
    logic [31:0]   instret_count;
`ifdef HARNESS_SIGNATURE_EN
    logic [DW-1:0] sig;
`endif

    sim_harness_ctrl #(
        .AW(AW), .DW(DW), .TOHOST_ADDR(TOHOST), .RST_CYCLES(RSTC),
        .MAX_CYCLES(MAXC), .HANG_CYCLES(HANGC), .CW(32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .core_rst_n    (core_rst_n),
        .running       (running),
        .done          (done),
        .status        (status),
        .hang          (hang),
        .fail_code     (fail_code),
`ifdef HARNESS_SIGNATURE_EN
        .sig           (sig),
`endif
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    typedef struct {
        logic [1:0]    status;
        logic          hang;
        logic [31:0]   cycles;
        logic [31:0]   instret;
        logic [DW-2:0] fail_code;
        logic [DW-1:0] sig;
    } exp_t;

    store_t plan[$];
    exp_t   sb[$];

    task automatic add_store(input int c, input logic [31:0] a, input logic [31:0] d);
        store_t s;
        s.cyc  = c;
        s.addr = a;
        s.data = d;
        plan.push_back(s);
    endtask

    task automatic clear_inputs();
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.retire   = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_rst_core_rst_n"}, core_rst_n, 0);
        check({name, "_rst_running"}, running, 0);
        check({name, "_rst_done"}, done, 0);
        check({name, "_rst_status"}, status, 0);
        check({name, "_rst_hang"}, hang, 0);
        check({name, "_rst_fail_code"}, fail_code, 0);
        check({name, "_rst_cycles"}, cycle_count, 0);
        check({name, "_rst_instret"}, instret_count, 0);
`ifdef HARNESS_SIGNATURE_EN
        check({name, "_rst_sig"}, sig, 0);
`endif
    endtask

    // Leaves the bench at the negedge of the first RUN cycle.
    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values(name);
        rst = 1'b0;
        for (int k = 1; k <= RSTC; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_core_rst_n_seq"}, core_rst_n, (k == RSTC));
        end
        check({name, "_run_running"}, running, 1);
        check({name, "_run_status"}, status, 0);
        check({name, "_run_cycles0"}, cycle_count, 0);
    endtask

    task automatic run_prog(input string name, input int retire_until);
        int          m_cyc  = 0;
        int          m_inst = 0;
        int          m_idle = 0;
        logic [31:0] m_sig  = '0;
        bit          term   = 1'b0;
        int          w      = 0;
        exp_t        e;
        exp_t        got;
        do_reset(name);
        for (int i = 0; i < 40 && !term; i++) begin
            clear_inputs();
            bus.retire = (i < retire_until);
            foreach (plan[j]) begin
                if (plan[j].cyc == i) begin
                    bus.st_valid = 1'b1;
                    bus.st_addr  = plan[j].addr;
                    bus.st_data  = plan[j].data;
                end
            end
            e.status    = 2'd0;
            e.hang      = 1'b0;
            e.fail_code = '0;
            if (bus.st_valid && bus.st_addr == TOHOST && bus.st_data[0]) begin
                term = 1'b1;
                if (bus.st_data == 32'd1) begin
                    e.status = 2'd1;
                end else begin
                    e.status    = 2'd2;
                    e.fail_code = bus.st_data[DW-1:1];
                end
            end else if (m_cyc == MAXC - 1) begin
                term     = 1'b1;
                e.status = 2'd3;
            end else if (m_idle == HANGC - 1 && !bus.retire) begin
                term     = 1'b1;
                e.status = 2'd3;
                e.hang   = 1'b1;
            end
            if (bus.st_valid)
                m_sig = {m_sig[30:0], m_sig[31]} ^ bus.st_data;
            m_cyc++;
            if (bus.retire) m_inst++;
            m_idle = bus.retire ? 0 : m_idle + 1;
            if (term) begin
                e.cycles  = m_cyc;
                e.instret = m_inst;
                e.sig     = m_sig;
                sb.push_back(e);
            end
            @(posedge clk);
            @(negedge clk);
        end
        clear_inputs();
        check({name, "_term_in_model"}, term, 1);
        while (!done && w < 4) begin
            @(negedge clk);
            w++;
        end
        check({name, "_done"}, done, 1);
        check({name, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({name, "_status"}, status, got.status);
            check({name, "_hang"}, hang, got.hang);
            check({name, "_cycles"}, cycle_count, got.cycles);
            check({name, "_instret"}, instret_count, got.instret);
            check({name, "_fail_code"}, fail_code, got.fail_code);
`ifdef HARNESS_SIGNATURE_EN
            check({name, "_sig"}, sig, got.sig);
`endif
            check({name, "_core_frozen"}, core_rst_n, 0);
            check({name, "_running_low"}, running, 0);
            repeat (3) @(negedge clk);
            check({name, "_cycles_hold"}, cycle_count, got.cycles);
            check({name, "_instret_hold"}, instret_count, got.instret);
            check({name, "_done_hold"}, done, 1);
        end
        plan.delete();
    endtask

    task automatic midrun();
        logic [31:0] m_sig = '0;
        do_reset("mid");
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            bus.retire = 1'b1;
            if (i == 1) begin
                bus.st_valid = 1'b1; bus.st_addr = 32'h3000; bus.st_data = 32'h1;
            end else if (i == 2) begin
                bus.st_valid = 1'b1; bus.st_addr = 32'h3004; bus.st_data = 32'h2;
            end else if (i == 3) begin
                bus.st_valid = 1'b1; bus.st_addr = TOHOST;   bus.st_data = 32'h4;
            end
            if (bus.st_valid)
                m_sig = {m_sig[30:0], m_sig[31]} ^ bus.st_data;
            @(posedge clk);
            @(negedge clk);
`ifdef HARNESS_SIGNATURE_EN
            if (i == 2) check("mid_sig_after_1_2", sig, m_sig);
            if (i == 3) check("mid_sig_after_even_tohost", sig, m_sig);
`endif
        end
        clear_inputs();
        check("mid_running", running, 1);
        check("mid_done", done, 0);
        check("mid_cycles", cycle_count, 8);
        check("mid_instret", instret_count, 8);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("mid_reset");
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        add_store(10, TOHOST, 32'd1);
        run_prog("pass", 1000);

        add_store(2, TOHOST, 32'd4);
        add_store(3, 32'h0000_2000, 32'd7);
        add_store(5, TOHOST, 32'd7);
        run_prog("fail", 1000);

        run_prog("timeout", 1000);

        add_store(19, TOHOST, 32'd1);
        run_prog("pass_at_last", 1000);

        run_prog("hang", 5);

        midrun();

        add_store(10, TOHOST, 32'd1);
        run_prog("rerun", 1000);
        check("rerun_cycles_11", cycle_count, 11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
